// File: rtl/rex_pkg.sv
// ---------------------------------------------------------------------------
// rex_pkg
// Shared definitions for the rex runner game controller: state encodings,
// output widths, default timing/score parameters and a saturating increment.
// No ports.
// ---------------------------------------------------------------------------
package rex_pkg;

    localparam int HEIGHT_W       = 8;
    localparam int SCORE_W        = 14;
    localparam int JUMP_TICKS_DEF = 16;
    localparam int JUMP_STEP_DEF  = 4;
    localparam int SCORE_MAX_DEF  = 9999;

    // One-hot so the state register bits are the registered output flags.
    typedef enum logic [5:0] {
        S_INI   = 6'b100000,
        S_RUN   = 6'b010000,
        S_JUMP  = 6'b001000,
        S_DUCK  = 6'b000100,
        S_PAUSE = 6'b000010,
        S_STOP  = 6'b000001
    } state_e;

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v,
                                                   input logic [SCORE_W-1:0] vmax);
        return (v >= vmax) ? vmax : v + SCORE_W'(1);
    endfunction

endpackage

// File: rtl/rex_game_ctrl_if.sv
// ---------------------------------------------------------------------------
// rex_game_ctrl_if
// Command/status bundle of the game controller.
//   Tick, Start, Restart, Jump, Pause, Collision : single-cycle pulses / level
//   Duck                                         : level
//   q_Start..q_Stop                              : one-hot state flags
//   jump_height, score, hi_score                 : status values
// modport slave  : the controller (consumes commands, drives status)
// modport master : the command source / observer
// ---------------------------------------------------------------------------
interface rex_game_ctrl_if;
    import rex_pkg::*;

    logic                Tick;
    logic                Start;
    logic                Restart;
    logic                Jump;
    logic                Pause;
    logic                Duck;
    logic                Collision;
    logic                q_Start;
    logic                q_Run;
    logic                q_Jump;
    logic                q_Duck;
    logic                q_Pause;
    logic                q_Stop;
    logic [HEIGHT_W-1:0] jump_height;
    logic [SCORE_W-1:0]  score;
    logic [SCORE_W-1:0]  hi_score;

    modport slave (
        input  Tick, Start, Restart, Jump, Pause, Duck, Collision,
        output q_Start, q_Run, q_Jump, q_Duck, q_Pause, q_Stop,
        output jump_height, score, hi_score
    );

    modport master (
        output Tick, Start, Restart, Jump, Pause, Duck, Collision,
        input  q_Start, q_Run, q_Jump, q_Duck, q_Pause, q_Stop,
        input  jump_height, score, hi_score
    );

endinterface

// File: rtl/rex_jump_arc.sv
// ---------------------------------------------------------------------------
// rex_jump_arc
// Jump counter and height profile: rises JUMP_STEP per tick for the first
// half of the jump, falls for the second half, lands at exactly 0.
//   Clk, Reset_n : clock, async active-low reset
//   i_load       : restart the arc (counter and height to 0); wins over tick
//   i_tick       : frame tick
//   i_freeze     : hold counter and height (not jumping, paused, colliding)
//   o_height     : registered height above ground
//   o_done       : this tick is the landing tick (combinational)
// ---------------------------------------------------------------------------
module rex_jump_arc
    import rex_pkg::*;
#(
    parameter int JUMP_TICKS = JUMP_TICKS_DEF,
    parameter int JUMP_STEP  = JUMP_STEP_DEF
) (
    input  logic                Clk,
    input  logic                Reset_n,
    input  logic                i_load,
    input  logic                i_tick,
    input  logic                i_freeze,
    output logic [HEIGHT_W-1:0] o_height,
    output logic                o_done
);

    localparam int CNT_W = (JUMP_TICKS > 2) ? $clog2(JUMP_TICKS) : 1;
    localparam logic [CNT_W-1:0]    CNT_HALF = CNT_W'(JUMP_TICKS / 2);
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(JUMP_TICKS - 1);
    localparam logic [HEIGHT_W-1:0] STEP     = HEIGHT_W'(JUMP_STEP);

    logic [CNT_W-1:0]    r_cnt;
    logic [HEIGHT_W-1:0] r_height;
    logic                w_step;

    assign w_step   = i_tick & ~i_freeze;
    assign o_done   = w_step & ~i_load & (r_cnt == CNT_LAST);
    assign o_height = r_height;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_cnt    <= '0;
            r_height <= '0;
        end else if (i_load) begin
            r_cnt    <= '0;
            r_height <= '0;
        end else if (w_step) begin
            if (r_cnt == CNT_LAST) begin
                // Force ground level rather than trusting the arithmetic.
                r_cnt    <= '0;
                r_height <= '0;
            end else begin
                r_cnt    <= r_cnt + CNT_W'(1);
                r_height <= (r_cnt < CNT_HALF) ? r_height + STEP : r_height - STEP;
            end
        end
    end

endmodule

// File: rtl/rex_game_ctrl.sv
// ---------------------------------------------------------------------------
// rex_game_ctrl
// Game-control FSM of the rex runner: state sequencing from player commands,
// collision and frame tick; running score with saturation; jump arc.
//   Clk     : system clock
//   Reset_n : async active-low reset
//   bus     : rex_game_ctrl_if.slave (commands in, flags/height/score out)
// Optional: define REX_HISCORE_EN to keep a best score captured on entering
// STOP; without it hi_score is constant 0.
//
// state | meaning
// INI   | waiting for Start
// RUN   | running on the ground, score counting
// JUMP  | jump arc in progress, score counting
// DUCK  | ducking, score counting
// PAUSE | frozen; saved state restored on next Pause
// STOP  | crashed; waits for Restart
// ---------------------------------------------------------------------------
module rex_game_ctrl
    import rex_pkg::*;
#(
    parameter int JUMP_TICKS = JUMP_TICKS_DEF,
    parameter int JUMP_STEP  = JUMP_STEP_DEF,
    parameter int SCORE_MAX  = SCORE_MAX_DEF
) (
    input  logic           Clk,
    input  logic           Reset_n,
    rex_game_ctrl_if.slave bus
);

    localparam logic [SCORE_W-1:0] SCORE_SAT = SCORE_W'(SCORE_MAX);

    state_e             r_state, w_state_next;
    state_e             r_saved, w_saved_next;
    logic [SCORE_W-1:0] r_score;
    logic               w_active;
    logic               w_score_inc;
    logic               w_arc_load;
    logic               w_arc_freeze;
    logic               w_arc_done;
    logic [HEIGHT_W-1:0] w_height;

    assign w_active = (r_state == S_RUN) | (r_state == S_JUMP) | (r_state == S_DUCK);

    // A tick only counts if nothing of higher priority takes the cycle.
    assign w_score_inc = bus.Tick & w_active & ~bus.Restart & ~bus.Collision & ~bus.Pause;

    // Arc restarts on Restart or when a Jump is accepted from RUN/DUCK.
    assign w_arc_load = bus.Restart
                      | (bus.Jump & ~bus.Collision & ~bus.Pause
                         & ((r_state == S_RUN) | (r_state == S_DUCK)));

    // Arc only moves while already in JUMP and not being stopped/paused.
    assign w_arc_freeze = (r_state != S_JUMP) | bus.Restart | bus.Collision | bus.Pause;

    rex_jump_arc #(
        .JUMP_TICKS (JUMP_TICKS),
        .JUMP_STEP  (JUMP_STEP)
    ) u_arc (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .i_load   (w_arc_load),
        .i_tick   (bus.Tick),
        .i_freeze (w_arc_freeze),
        .o_height (w_height),
        .o_done   (w_arc_done)
    );

    always_comb begin
        w_state_next = r_state;
        w_saved_next = r_saved;
        if (bus.Restart) begin
            w_state_next = S_INI;
        end else begin
            case (r_state)
                S_INI: begin
                    if (bus.Start) w_state_next = S_RUN;
                end
                S_RUN: begin
                    if (bus.Collision) begin
                        w_state_next = S_STOP;
                    end else if (bus.Pause) begin
                        w_saved_next = S_RUN;
                        w_state_next = S_PAUSE;
                    end else if (bus.Jump) begin
                        w_state_next = S_JUMP;
                    end else if (bus.Duck) begin
                        w_state_next = S_DUCK;
                    end
                end
                S_JUMP: begin
                    if (bus.Collision) begin
                        w_state_next = S_STOP;
                    end else if (bus.Pause) begin
                        w_saved_next = S_JUMP;
                        w_state_next = S_PAUSE;
                    end else if (w_arc_done) begin
                        w_state_next = bus.Duck ? S_DUCK : S_RUN;
                    end
                end
                S_DUCK: begin
                    if (bus.Collision) begin
                        w_state_next = S_STOP;
                    end else if (bus.Pause) begin
                        w_saved_next = S_DUCK;
                        w_state_next = S_PAUSE;
                    end else if (bus.Jump) begin
                        w_state_next = S_JUMP;
                    end else if (!bus.Duck) begin
                        w_state_next = S_RUN;
                    end
                end
                S_PAUSE: begin
                    if (bus.Pause) begin
                        w_state_next = (r_saved == S_DUCK && !bus.Duck) ? S_RUN : r_saved;
                    end
                end
                S_STOP: begin
                    w_state_next = S_STOP;
                end
                default: begin
                    w_state_next = S_INI;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= S_INI;
            r_saved <= S_RUN;
        end else begin
            r_state <= w_state_next;
            r_saved <= w_saved_next;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_score <= '0;
        end else if (bus.Restart) begin
            r_score <= '0;
        end else if (w_score_inc) begin
            r_score <= sat_inc(r_score, SCORE_SAT);
        end
    end

`ifdef REX_HISCORE_EN
    logic [SCORE_W-1:0] r_hi_score;

    // Score never increments on the collision cycle, so r_score is final here.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_hi_score <= '0;
        end else if (w_state_next == S_STOP && r_state != S_STOP && r_score > r_hi_score) begin
            r_hi_score <= r_score;
        end
    end

    assign bus.hi_score = r_hi_score;
`else
    assign bus.hi_score = '0;
`endif

    assign bus.q_Start     = r_state[5];
    assign bus.q_Run       = r_state[4];
    assign bus.q_Jump      = r_state[3];
    assign bus.q_Duck      = r_state[2];
    assign bus.q_Pause     = r_state[1];
    assign bus.q_Stop      = r_state[0];
    assign bus.jump_height = w_height;
    assign bus.score       = r_score;

endmodule

// File: tb/tb_rex_game_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rex_game_ctrl
// Directed scenarios plus a randomized run against a behavioural model of the
// rex game controller. Define REX_HISCORE_EN to expect a live best score.
// ---------------------------------------------------------------------------
module tb_rex_game_ctrl;

    localparam int T    = 16;
    localparam int STEP = 4;
    localparam int SMAX = 9999;

    localparam int MI = 0, MR = 1, MJ = 2, MD = 3, MP = 4, MS = 5;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    // Behavioural model: mode, saved mode, ticks into jump, score, best score.
    int m_mode, m_saved, m_k, m_score, m_hi;

    rex_game_ctrl_if bus();

    rex_game_ctrl dut (
        .Clk     (clk),
        .Reset_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [5:0] exp_flags(input int md);
        case (md)
            MI:      return 6'b100000;
            MR:      return 6'b010000;
            MJ:      return 6'b001000;
            MD:      return 6'b000100;
            MP:      return 6'b000010;
            default: return 6'b000001;
        endcase
    endfunction

    function automatic int exp_height();
        return STEP * ((m_k <= T / 2) ? m_k : T - m_k);
    endfunction

    function automatic logic [5:0] dut_flags();
        return {bus.q_Start, bus.q_Run, bus.q_Jump, bus.q_Duck, bus.q_Pause, bus.q_Stop};
    endfunction

    task automatic model_reset();
        m_mode = MI; m_saved = MR; m_k = 0; m_score = 0; m_hi = 0;
    endtask

    task automatic model_step(input bit tk, st, rs, jp, ps, cl, dk);
        int prev;
        bit active;
        prev   = m_mode;
        active = (m_mode == MR) || (m_mode == MJ) || (m_mode == MD);
        if (rs) begin
            m_mode = MI; m_score = 0; m_k = 0;
        end else begin
            if (tk && active && !cl && !ps) m_score = (m_score >= SMAX) ? SMAX : m_score + 1;
            case (m_mode)
                MI: if (st) m_mode = MR;
                MR: begin
                    if (cl) m_mode = MS;
                    else if (ps) begin m_saved = MR; m_mode = MP; end
                    else if (jp) begin m_mode = MJ; m_k = 0; end
                    else if (dk) m_mode = MD;
                end
                MJ: begin
                    if (cl) m_mode = MS;
                    else if (ps) begin m_saved = MJ; m_mode = MP; end
                    else if (tk) begin
                        m_k++;
                        if (m_k == T) begin m_k = 0; m_mode = dk ? MD : MR; end
                    end
                end
                MD: begin
                    if (cl) m_mode = MS;
                    else if (ps) begin m_saved = MD; m_mode = MP; end
                    else if (jp) begin m_mode = MJ; m_k = 0; end
                    else if (!dk) m_mode = MR;
                end
                MP: if (ps) m_mode = (m_saved == MD && !dk) ? MR : m_saved;
                default: ;
            endcase
        end
`ifdef REX_HISCORE_EN
        if (m_mode == MS && prev != MS && m_score > m_hi) m_hi = m_score;
`endif
    endtask

    // One clock: drive pulses at negedge, step the model, sample 1 ns after posedge.
    task automatic cycle(input bit tk, st, rs, jp, ps, cl);
        @(negedge clk);
        bus.Tick = tk; bus.Start = st; bus.Restart = rs;
        bus.Jump = jp; bus.Pause = ps; bus.Collision = cl;
        model_step(tk, st, rs, jp, ps, cl, bus.Duck);
        @(posedge clk);
        #1;
        bus.Tick = 0; bus.Start = 0; bus.Restart = 0;
        bus.Jump = 0; bus.Pause = 0; bus.Collision = 0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, 0, 0);
    endtask

    task automatic restart_and_start();
        cycle(0, 0, 1, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 0;
        bus.Tick = 0; bus.Start = 0; bus.Restart = 0; bus.Jump = 0;
        bus.Pause = 0; bus.Duck = 0; bus.Collision = 0;
        model_reset();
        #2;
        n_checks++; if (dut_flags() !== 6'b100000) $display("FAIL reset_flags: got %b want 100000", dut_flags()); else n_pass++;
        n_checks++; if (bus.score !== 14'd0) $display("FAIL reset_score: got %0d want 0", bus.score); else n_pass++;
        n_checks++; if (bus.jump_height !== 8'd0) $display("FAIL reset_height: got %0d want 0", bus.jump_height); else n_pass++;
        n_checks++; if (bus.hi_score !== 14'd0) $display("FAIL reset_hi: got %0d want 0", bus.hi_score); else n_pass++;
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_run_score();
        cycle(0, 1, 0, 0, 0, 0);
        ticks(5);
        n_checks++; if (bus.q_Run !== 1'b1) $display("FAIL run_flag: got %b want 1", bus.q_Run); else n_pass++;
        n_checks++; if (bus.score !== 14'd5) $display("FAIL run_score: got %0d want 5", bus.score); else n_pass++;
        cycle(0, 0, 0, 0, 0, 1);
        ticks(3);
        n_checks++; if (dut_flags() !== 6'b000001) $display("FAIL stop_flags: got %b want 000001", dut_flags()); else n_pass++;
        n_checks++; if (bus.score !== 14'd5) $display("FAIL stop_score_hold: got %0d want 5", bus.score); else n_pass++;
        cycle(0, 1, 0, 1, 1, 0);
        n_checks++; if (bus.q_Stop !== 1'b1) $display("FAIL stop_ignores_cmds: got %b want 1", bus.q_Stop); else n_pass++;
    endtask

    task automatic test_jump_arc();
        int h;
        restart_and_start();
        cycle(1, 0, 0, 1, 0, 0);
        n_checks++; if (bus.q_Jump !== 1'b1 || bus.jump_height !== 8'd0)
            $display("FAIL jump_entry: q_Jump=%b height=%0d want 1/0", bus.q_Jump, bus.jump_height); else n_pass++;
        for (int i = 1; i <= T; i++) begin
            cycle(1, 0, 0, 0, 0, 0);
            h = STEP * ((i <= T / 2) ? i : T - i);
            n_checks++; if (bus.jump_height !== h[7:0])
                $display("FAIL jump_height_t%0d: got %0d want %0d", i, bus.jump_height, h); else n_pass++;
        end
        n_checks++; if (dut_flags() !== 6'b010000) $display("FAIL jump_land_run: got %b want 010000", dut_flags()); else n_pass++;
        cycle(0, 0, 0, 1, 0, 0);
        ticks(T - 1);
        bus.Duck = 1;
        cycle(1, 0, 0, 0, 0, 0);
        n_checks++; if (dut_flags() !== 6'b000100 || bus.jump_height !== 8'd0)
            $display("FAIL jump_land_duck: flags=%b height=%0d want 000100/0", dut_flags(), bus.jump_height); else n_pass++;
        bus.Duck = 0;
        cycle(0, 0, 0, 0, 0, 0);
        n_checks++; if (bus.q_Run !== 1'b1) $display("FAIL duck_release: got %b want 1", bus.q_Run); else n_pass++;
    endtask

    task automatic test_pause_jump();
        restart_and_start();
        cycle(0, 0, 0, 1, 0, 0);
        ticks(3);
        n_checks++; if (bus.jump_height !== 8'd12) $display("FAIL pause_pre_height: got %0d want 12", bus.jump_height); else n_pass++;
        cycle(1, 0, 0, 0, 1, 0);
        for (int i = 0; i < 10; i++) cycle(1, 0, 0, 1, 0, 1);
        n_checks++; if (bus.q_Pause !== 1'b1) $display("FAIL pause_flag: got %b want 1", bus.q_Pause); else n_pass++;
        n_checks++; if (bus.jump_height !== 8'd12) $display("FAIL pause_height: got %0d want 12", bus.jump_height); else n_pass++;
        n_checks++; if (bus.score !== 14'd3) $display("FAIL pause_score: got %0d want 3", bus.score); else n_pass++;
        cycle(0, 0, 0, 0, 1, 0);
        n_checks++; if (bus.q_Jump !== 1'b1) $display("FAIL pause_resume: got %b want 1", bus.q_Jump); else n_pass++;
        cycle(1, 0, 0, 0, 0, 0);
        n_checks++; if (bus.jump_height !== 8'd16 || bus.score !== 14'd4)
            $display("FAIL pause_continue: height=%0d score=%0d want 16/4", bus.jump_height, bus.score); else n_pass++;
    endtask

    task automatic test_tick_collision();
        restart_and_start();
        ticks(7);
        cycle(1, 0, 0, 0, 0, 1);
        n_checks++; if (bus.q_Stop !== 1'b1 || bus.score !== 14'd7)
            $display("FAIL tick_coll: q_Stop=%b score=%0d want 1/7", bus.q_Stop, bus.score); else n_pass++;
        cycle(0, 0, 1, 0, 0, 0);
        n_checks++; if (dut_flags() !== 6'b100000 || bus.score !== 14'd0)
            $display("FAIL restart: flags=%b score=%0d want 100000/0", dut_flags(), bus.score); else n_pass++;
    endtask

    task automatic test_saturation();
        restart_and_start();
        ticks(SMAX - 1);
        n_checks++; if (bus.score !== 14'(SMAX - 1)) $display("FAIL sat_pre: got %0d want %0d", bus.score, SMAX - 1); else n_pass++;
        ticks(3);
        n_checks++; if (bus.score !== 14'(SMAX)) $display("FAIL sat_hold: got %0d want %0d", bus.score, SMAX); else n_pass++;
    endtask

    task automatic test_hiscore();
        int want;
        restart_and_start();
        ticks(20);
        cycle(0, 0, 0, 0, 0, 1);
`ifdef REX_HISCORE_EN
        want = 20;
`else
        want = 0;
`endif
        n_checks++; if (bus.hi_score !== 14'(want)) $display("FAIL hi_first: got %0d want %0d", bus.hi_score, want); else n_pass++;
        restart_and_start();
        ticks(10);
        cycle(0, 0, 0, 0, 0, 1);
        n_checks++; if (bus.hi_score !== 14'(want)) $display("FAIL hi_keep: got %0d want %0d", bus.hi_score, want); else n_pass++;
        test_reset();
    endtask

    task automatic test_random();
        bit tk, st, rs, jp, ps, cl;
        int h;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(99) < 5) bus.Duck = ~bus.Duck;
            tk = ($urandom_range(99) < 50);
            st = ($urandom_range(99) < 10);
            rs = ($urandom_range(99) < 2);
            jp = ($urandom_range(99) < 10);
            ps = ($urandom_range(99) < 5);
            cl = ($urandom_range(99) < 2);
            cycle(tk, st, rs, jp, ps, cl);
            h = exp_height();
            n_checks++; if (dut_flags() !== exp_flags(m_mode))
                $display("FAIL rnd_flags c%0d: got %b want %b", c, dut_flags(), exp_flags(m_mode)); else n_pass++;
            n_checks++; if (bus.jump_height !== h[7:0])
                $display("FAIL rnd_height c%0d: got %0d want %0d", c, bus.jump_height, h); else n_pass++;
            n_checks++; if (bus.score !== 14'(m_score))
                $display("FAIL rnd_score c%0d: got %0d want %0d", c, bus.score, m_score); else n_pass++;
            n_checks++; if (bus.hi_score !== 14'(m_hi))
                $display("FAIL rnd_hi c%0d: got %0d want %0d", c, bus.hi_score, m_hi); else n_pass++;
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1;
        test_reset();
        test_run_score();
        test_jump_arc();
        test_pause_jump();
        test_tick_collision();
        test_saturation();
        test_hiscore();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
